// File: rtl/ofifo.sv
// ofifo: per-lane output FIFO draining the systolic array, popped a whole row at a time; OFIFO_ERR_EN adds sticky o_ovf/o_unf
module ofifo #(
    parameter int col     = 8,
    parameter int psum_bw = 16,
    parameter int depth   = 64
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [col*psum_bw-1:0] in,
    input  logic [col-1:0]         wr,
    input  logic                   rd,
    output logic [col*psum_bw-1:0] out,
    output logic                   o_full,
    output logic                   o_ready,
`ifdef OFIFO_ERR_EN
    output logic                   o_ovf,
    output logic                   o_unf,
`endif
    output logic                   o_valid
);
    localparam int AW = $clog2(depth);
    logic [AW:0]    rptr_q, rptr_d;
    logic [col-1:0] empty, full, push;
    logic           pop;
    assign o_valid = ~|empty;
    assign o_full  = |full;
    assign o_ready = ~o_full;
    assign pop     = rd & o_valid;
    assign rptr_d  = rptr_q + (AW+1)'(pop);
    // shared read pointer advances on every accepted row pop
    always_ff @(posedge clk) begin
        rptr_q <= reset ? '0 : rptr_d;
    end
    for (genvar i = 0; i < col; i++) begin : g_lane
        logic [AW:0]        wptr_q, wptr_d;
        logic [psum_bw-1:0] mem_q [depth];
        assign empty[i] = wptr_q == rptr_q;
        assign full[i]  = wptr_q[AW-1:0] == rptr_q[AW-1:0] && wptr_q[AW] != rptr_q[AW];
        assign push[i]  = wr[i] & (~full[i] | pop);
        assign wptr_d   = wptr_q + (AW+1)'(push[i]);
        // per-lane write pointer; a same-cycle pop frees the slot a full lane writes into
        always_ff @(posedge clk) begin
            wptr_q <= reset ? '0 : wptr_d;
        end
        // storage is never cleared; reset only rewinds the pointers
        always_ff @(posedge clk) begin
            if (push[i] && !reset) mem_q[wptr_q[AW-1:0]] <= in[psum_bw*i +: psum_bw];
        end
        assign out[psum_bw*i +: psum_bw] = o_valid ? mem_q[rptr_q[AW-1:0]] : '0;
    end
`ifdef OFIFO_ERR_EN
    logic ovf_q, ovf_d, unf_q, unf_d;
    assign ovf_d = ovf_q | (|(wr & full & {col{~pop}}));
    assign unf_d = unf_q | (rd & ~o_valid);
    assign o_ovf = ovf_q;
    assign o_unf = unf_q;
    // sticky error flags held until reset
    always_ff @(posedge clk) begin
        ovf_q <= reset ? 1'b0 : ovf_d;
        unf_q <= reset ? 1'b0 : unf_d;
    end
`endif
endmodule
